// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Brief    : N-channel debouncer: synchroniser, stability counter, clean level,
//            rise/fall pulses. Long-press detection when DEBOUNCE_LONGPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned LONG_CYCLES   = 100000000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] noisy_in_i,
    output logic [N_CH-1:0] clean_out_o,
    output logic [N_CH-1:0] rise_pulse_o,
    output logic [N_CH-1:0] fall_pulse_o,
    output logic [N_CH-1:0] long_press_o
);

    localparam int unsigned        c_cnt_w   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES - 1);

    genvar ch;
    generate
        for (ch = 0; ch < N_CH; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   cand_q, cand_d;
            logic [c_cnt_w-1:0]     cnt_q, cnt_d;
            logic                   clean_q, clean_d;
            logic                   rise_q, fall_q;
            logic                   w_sync_s;

            assign w_sync_s = sync_q[SYNC_STAGES-1];

            // A mismatch against the candidate restarts the count; the
            // counter parks at its terminal value while the level is stable.
            always_comb begin
                cand_d  = cand_q;
                cnt_d   = cnt_q;
                clean_d = clean_q;
                if (w_sync_s != cand_q) begin
                    cand_d = w_sync_s;
                    cnt_d  = '0;
                end else if (cnt_q != c_cnt_max) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    clean_d = cand_q;
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
                    cand_q  <= INIT_LEVEL;
                    cnt_q   <= '0;
                    clean_q <= INIT_LEVEL;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy_in_i[ch]};
                    cand_q  <= cand_d;
                    cnt_q   <= cnt_d;
                    clean_q <= clean_d;
                    rise_q  <= clean_d & ~clean_q;
                    fall_q  <= ~clean_d & clean_q;
                end
            end

            assign clean_out_o[ch]  = clean_q;
            assign rise_pulse_o[ch] = rise_q;
            assign fall_pulse_o[ch] = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
            localparam int unsigned         c_hold_w   = $clog2(LONG_CYCLES + 1);
            localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CYCLES);
            localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(LONG_CYCLES - 1);

            logic [c_hold_w-1:0] hold_q, hold_d;
            logic                long_q, long_d;

            // Pulse on the edge where the hold count lands on its limit;
            // saturation then blocks any repeat until the level drops.
            always_comb begin
                hold_d = '0;
                long_d = 1'b0;
                if (clean_q) begin
                    hold_d = (hold_q == c_hold_max) ? hold_q : hold_q + 1'b1;
                    long_d = (hold_q == c_hold_pre);
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    long_q <= long_d;
                end
            end

            assign long_press_o[ch] = long_q;
`else
            localparam int unsigned c_unused_long = LONG_CYCLES;
            assign long_press_o[ch] = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire
